// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vga_timing_pkg
// Description : Shared definitions for the VGA mode sequencer: supported mode
//               codes, the ten-word timing set, sequencer state encoding and
//               the mode-to-timing lookup used by the ROM and reset values.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

  localparam int TIMING_W = 12;

  localparam logic [3:0] MODE_640x480  = 4'b0001;
  localparam logic [3:0] MODE_800x600  = 4'b0101;
  localparam logic [3:0] MODE_1024x768 = 4'b0010;

  typedef struct packed {
    logic [TIMING_W-1:0] h_visible;
    logic [TIMING_W-1:0] h_front;
    logic [TIMING_W-1:0] h_sync;
    logic [TIMING_W-1:0] h_back;
    logic [TIMING_W-1:0] h_whole;
    logic [TIMING_W-1:0] v_visible;
    logic [TIMING_W-1:0] v_front;
    logic [TIMING_W-1:0] v_sync;
    logic [TIMING_W-1:0] v_back;
    logic [TIMING_W-1:0] v_whole;
  } timing_t;

  localparam logic [1:0] SETTLE     = 2'd0;
  localparam logic [1:0] RUN        = 2'd1;
  localparam logic [1:0] WAIT_FRAME = 2'd2;

  function automatic logic mode_supported(input logic [3:0] mode);
    return (mode == MODE_640x480) || (mode == MODE_800x600) ||
           (mode == MODE_1024x768);
  endfunction

  // Unsupported codes return an all-zero set; callers gate on mode_supported.
  function automatic timing_t mode_timing(input logic [3:0] mode);
    timing_t t;
    t = '0;
    case (mode)
      MODE_640x480: begin
        t.h_visible = 12'd640;  t.h_front = 12'd16; t.h_sync = 12'd96;
        t.h_back    = 12'd48;   t.h_whole = 12'd800;
        t.v_visible = 12'd480;  t.v_front = 12'd10; t.v_sync = 12'd2;
        t.v_back    = 12'd33;   t.v_whole = 12'd525;
      end
      MODE_800x600: begin
        t.h_visible = 12'd800;  t.h_front = 12'd56; t.h_sync = 12'd120;
        t.h_back    = 12'd64;   t.h_whole = 12'd1040;
        t.v_visible = 12'd600;  t.v_front = 12'd37; t.v_sync = 12'd6;
        t.v_back    = 12'd23;   t.v_whole = 12'd666;
      end
      MODE_1024x768: begin
        t.h_visible = 12'd1024; t.h_front = 12'd24; t.h_sync = 12'd136;
        t.h_back    = 12'd160;  t.h_whole = 12'd1344;
        t.v_visible = 12'd768;  t.v_front = 12'd3;  t.v_sync = 12'd6;
        t.v_back    = 12'd29;   t.v_whole = 12'd806;
      end
      default: t = '0;
    endcase
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_mode_rom.sv
`default_nettype none
// ============================================================================
// Module      : vga_mode_rom
// Description : Purely combinational mode-code to timing-set lookup.
// Ports       : mode_i      - mode code to look up
//               timing_o    - ten-word timing set for mode_i
//               supported_o - high when mode_i is a supported code
// Revision    : 1.0 - initial release
// ============================================================================
module vga_mode_rom
  import vga_timing_pkg::*;
(
  input  logic [3:0] mode_i,
  output timing_t    timing_o,
  output logic       supported_o
);

  assign timing_o    = mode_timing(mode_i);
  assign supported_o = mode_supported(mode_i);

endmodule
`default_nettype wire

// File: rtl/vga_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : vga_mode_sequencer
// Description : Owns the timing words of the H/V sync counter pair. Accepts
//               mode-change requests, defers each switch to a frame boundary
//               (or a timeout), loads all timing words atomically, then holds
//               the counters in reset for a settle window.
// Ports       : clk, rst (async, active-high)
//               req_valid/req_mode/req_ready - mode request handshake
//               frame_end    - last-line wrap pulse from the vertical counter
//               counter_hold - reset for the sync counters
//               h_* / v_*    - registered timing words
//               cur_mode, mode_done, mode_err - status
// Revision    : 1.0 - initial release
// ============================================================================
module vga_mode_sequencer
  import vga_timing_pkg::*;
#(
  parameter int         W             = 12,
  parameter int         SETTLE_CYCLES = 16,
  parameter int         FRAME_TIMEOUT = 1048576,
  parameter logic [3:0] DEFAULT_MODE  = 4'b0001
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req_valid,
  input  logic [3:0]   req_mode,
  output logic         req_ready,
  input  logic         frame_end,
  output logic         counter_hold,
  output logic [W-1:0] h_visible,
  output logic [W-1:0] h_front,
  output logic [W-1:0] h_sync,
  output logic [W-1:0] h_back,
  output logic [W-1:0] h_whole,
  output logic [W-1:0] v_visible,
  output logic [W-1:0] v_front,
  output logic [W-1:0] v_sync,
  output logic [W-1:0] v_back,
  output logic [W-1:0] v_whole,
  output logic [3:0]   cur_mode,
  output logic         mode_done,
  output logic         mode_err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = (FRAME_TIMEOUT > 1) ? $clog2(FRAME_TIMEOUT) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(FRAME_TIMEOUT - 1);
  localparam timing_t       DEF_TIMING  = mode_timing(DEFAULT_MODE);

  logic [1:0]    state_q, state_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [3:0]    pending_q, pending_d;
  logic [3:0]    cur_mode_q, cur_mode_d;
  timing_t       timing_q, timing_d;
  logic          switched_q, switched_d;   // current settle follows a switch
  logic          mode_done_q, mode_done_d;
  logic          mode_err_q, mode_err_d;

  logic [3:0]    rom_mode;
  timing_t       rom_timing;
  logic          rom_supported;

  // One ROM serves both jobs: in RUN it qualifies the incoming request, in
  // WAIT_FRAME it supplies the words for the latched pending mode.
  assign rom_mode = (state_q == RUN) ? req_mode : pending_q;

  vga_mode_rom u_rom (
    .mode_i      (rom_mode),
    .timing_o    (rom_timing),
    .supported_o (rom_supported)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
    pending_d    = pending_q;
    cur_mode_d   = cur_mode_q;
    timing_d     = timing_q;
    switched_d   = switched_q;
    mode_done_d  = 1'b0;
    mode_err_d   = 1'b0;
    case (state_q)
      SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d      = RUN;
          settle_cnt_d = '0;
          mode_done_d  = switched_q;  // silent after reset
          switched_d   = 1'b0;
        end else begin
          settle_cnt_d = settle_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (req_valid) begin
          if (!rom_supported) begin
            mode_err_d = 1'b1;
          end else if (req_mode == cur_mode_q) begin
            mode_done_d = 1'b1;
          end else begin
            pending_d = req_mode;
            tmo_cnt_d = '0;
            state_d   = WAIT_FRAME;
          end
        end
      end
      WAIT_FRAME: begin
        if (frame_end || (tmo_cnt_q == TMO_LAST)) begin
          timing_d     = rom_timing;
          cur_mode_d   = pending_q;
          settle_cnt_d = '0;
          switched_d   = 1'b1;
          state_d      = SETTLE;
        end else begin
          // Leaves the state at TMO_LAST, so the count never wraps.
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      default: begin
        state_d      = SETTLE;
        settle_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= SETTLE;
      settle_cnt_q <= '0;
      tmo_cnt_q    <= '0;
      pending_q    <= DEFAULT_MODE;
      cur_mode_q   <= DEFAULT_MODE;
      timing_q     <= DEF_TIMING;
      switched_q   <= 1'b0;
      mode_done_q  <= 1'b0;
      mode_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
      pending_q    <= pending_d;
      cur_mode_q   <= cur_mode_d;
      timing_q     <= timing_d;
      switched_q   <= switched_d;
      mode_done_q  <= mode_done_d;
      mode_err_q   <= mode_err_d;
    end
  end

  assign counter_hold = (state_q == SETTLE);
  assign req_ready    = (state_q == RUN);
  assign cur_mode     = cur_mode_q;
  assign mode_done    = mode_done_q;
  assign mode_err     = mode_err_q;

  assign h_visible = W'(timing_q.h_visible);
  assign h_front   = W'(timing_q.h_front);
  assign h_sync    = W'(timing_q.h_sync);
  assign h_back    = W'(timing_q.h_back);
  assign h_whole   = W'(timing_q.h_whole);
  assign v_visible = W'(timing_q.v_visible);
  assign v_front   = W'(timing_q.v_front);
  assign v_sync    = W'(timing_q.v_sync);
  assign v_back    = W'(timing_q.v_back);
  assign v_whole   = W'(timing_q.v_whole);

endmodule
`default_nettype wire

// File: tb/tb_vga_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_mode_sequencer
// Description : Directed self-checking bench for vga_mode_sequencer with a
//               scoreboard of expected done/err events.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_mode_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic [3:0]  req_mode = 4'd0;
  logic        req_ready;
  logic        frame_end = 1'b0;
  logic        counter_hold;
  logic [11:0] h_visible, h_front, h_sync, h_back, h_whole;
  logic [11:0] v_visible, v_front, v_sync, v_back, v_whole;
  logic [3:0]  cur_mode;
  logic        mode_done, mode_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_err;
    logic [3:0]  mode;
    logic [11:0] hw;
    logic [11:0] vw;
    logic [11:0] hv;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  vga_mode_sequencer #(
    .W(12), .SETTLE_CYCLES(16), .FRAME_TIMEOUT(64), .DEFAULT_MODE(4'b0001)
  ) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_mode(req_mode),
    .req_ready(req_ready), .frame_end(frame_end), .counter_hold(counter_hold),
    .h_visible(h_visible), .h_front(h_front), .h_sync(h_sync),
    .h_back(h_back), .h_whole(h_whole),
    .v_visible(v_visible), .v_front(v_front), .v_sync(v_sync),
    .v_back(v_back), .v_whole(v_whole),
    .cur_mode(cur_mode), .mode_done(mode_done), .mode_err(mode_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_default_set(input string tag);
    chk({tag, "_hvis"}, 32'(h_visible), 640);
    chk({tag, "_hwhole"}, 32'(h_whole), 800);
    chk({tag, "_vwhole"}, 32'(v_whole), 525);
    chk({tag, "_vsync"}, 32'(v_sync), 2);
    chk({tag, "_mode"}, 32'(cur_mode), 1);
  endtask

  // Counts consecutive samples with counter_hold high, then checks the
  // first sample after it drops for the absence of any status pulse.
  task automatic settle_no_done(input string tag);
    int n = 0;
    while (counter_hold && n < 40) begin
      chk({tag, "_ready_low"}, 32'(req_ready), 0);
      n++;
      tick();
    end
    chk({tag, "_hold_len"}, n, 16);
    chk({tag, "_no_done"}, 32'(mode_done), 0);
    chk({tag, "_no_err"}, 32'(mode_err), 0);
  endtask

  task automatic request(input logic [3:0] m);
    chk("req_ready_before_req", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_mode  = m;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic expect_event(input string tag);
    int   n = 0;
    exp_t e;
    while (!(mode_done || mode_err) && n < 100) begin
      n++;
      tick();
    end
    if (n >= 100) begin
      chk({tag, "_timeout"}, 1, 0);
    end else if (sb.size() == 0) begin
      chk({tag, "_unexpected_event"}, 1, 0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_err"}, 32'(mode_err), 32'(e.is_err));
      chk({tag, "_done"}, 32'(mode_done), 32'(!e.is_err));
      chk({tag, "_mode"}, 32'(cur_mode), 32'(e.mode));
      chk({tag, "_hwhole"}, 32'(h_whole), 32'(e.hw));
      chk({tag, "_vwhole"}, 32'(v_whole), 32'(e.vw));
      chk({tag, "_hvis"}, 32'(h_visible), 32'(e.hv));
      tick();
      chk({tag, "_pulse_end"}, 32'(mode_done | mode_err), 0);
    end
  endtask

  initial begin
    int n;
    int bad;

    // 1. reset state and settle after release
    tick(); tick();
    chk("rst_hold", 32'(counter_hold), 1);
    chk("rst_ready", 32'(req_ready), 0);
    chk("rst_done", 32'(mode_done), 0);
    chk("rst_err", 32'(mode_err), 0);
    chk_default_set("rst");
    rst = 1'b0;
    settle_no_done("boot");
    chk_default_set("boot");

    // 4. same-mode request is a no-op that reports done
    sb.push_back('{0, 4'b0001, 12'd800, 12'd525, 12'd640});
    request(4'b0001);
    expect_event("same_mode");
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (counter_hold !== 1'b0) bad++;
      tick();
    end
    chk("same_mode_no_hold", bad, 0);

    // 3. unsupported mode is rejected
    sb.push_back('{1, 4'b0001, 12'd800, 12'd525, 12'd640});
    request(4'b1111);
    chk("bad_mode_hold", 32'(counter_hold), 0);
    chk("bad_mode_ready", 32'(req_ready), 1);
    expect_event("bad_mode");
    chk("bad_mode_ready_after", 32'(req_ready), 1);

    // 2. switch to 800x600 on frame_end 40 cycles after acceptance
    sb.push_back('{0, 4'b0101, 12'd1040, 12'd666, 12'd800});
    request(4'b0101);
    bad = 0;
    for (int i = 0; i < 39; i++) begin
      if (req_ready !== 1'b0 || counter_hold !== 1'b0 || h_whole !== 12'd800) bad++;
      tick();
    end
    chk("wait_ready_low", bad, 0);
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("sw1_hvis", 32'(h_visible), 800);
    chk("sw1_vwhole", 32'(v_whole), 666);
    chk("sw1_hsync", 32'(h_sync), 120);
    chk("sw1_mode", 32'(cur_mode), 5);
    chk("sw1_hold", 32'(counter_hold), 1);
    n = 0;
    while (counter_hold && n < 40) begin
      n++;
      tick();
    end
    chk("sw1_hold_len", n, 16);
    expect_event("sw1");

    // 5. switch to 1024x768 by timeout (no frame_end)
    sb.push_back('{0, 4'b0010, 12'd1344, 12'd806, 12'd1024});
    request(4'b0010);
    n = 0;
    while (h_whole == 12'd1040 && n < 200) begin
      n++;
      tick();
    end
    chk("tmo_cycles", n, 64);
    chk("tmo_hwhole", 32'(h_whole), 1344);
    chk("tmo_hold", 32'(counter_hold), 1);
    expect_event("tmo");

    // 6a. reset in WAIT_FRAME
    request(4'b0101);
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1;
    #1;
    chk("rst_wait_hold", 32'(counter_hold), 1);
    chk("rst_wait_ready", 32'(req_ready), 0);
    chk_default_set("rst_wait");
    tick();
    rst = 1'b0;
    settle_no_done("rst_wait_settle");
    chk_default_set("rst_wait_after");

    // 6b. reset in SETTLE
    request(4'b0101);
    for (int i = 0; i < 5; i++) tick();
    frame_end = 1'b1;
    tick();
    frame_end = 1'b0;
    chk("pre_rst_settle_mode", 32'(cur_mode), 5);
    for (int i = 0; i < 5; i++) tick();
    rst = 1'b1;
    #1;
    chk("rst_settle_hold", 32'(counter_hold), 1);
    chk_default_set("rst_settle");
    tick();
    rst = 1'b0;
    settle_no_done("rst_settle_settle");
    chk("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
